// File: rtl/morse_keyer_pkg.sv
// Shared Morse keyer types: FSM encodings, element/gap lengths in units, and the ROM entry layout.
// Unit lengths are stored as units-1 in the keyer's 2-bit unit counter.
package morse_keyer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MARK = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int ELEM_GAP   = 1;
  localparam int CHAR_GAP   = 3;
  localparam int WORD_EXTRA = 4;

  // pattern: 1 = dash, 0 = dot; first element sent is pattern[len-1]
  typedef struct packed {
    logic       valid;
    logic       is_space;
    logic [2:0] len;
    logic [4:0] pattern;
  } rom_entry_t;

  function automatic logic [1:0] units_m1(input int units);
    return 2'(units - 1);
  endfunction

  function automatic rom_entry_t sym(input logic [2:0] l, input logic [4:0] p);
    rom_entry_t e;
    e.valid    = 1'b1;
    e.is_space = 1'b0;
    e.len      = l;
    e.pattern  = p;
    return e;
  endfunction

endpackage

// File: rtl/morse_keyer_rom.sv
// Combinational ASCII to Morse lookup (A-Z case-folded, 0-9, space); zero latency, no backpressure.
// Any other code returns valid=0 so the keyer drops it.
module morse_keyer_rom
  import morse_keyer_pkg::*;
(
  input  logic [7:0] ascii,
  output rom_entry_t entry
);

  logic [7:0] folded;

  assign folded = (ascii >= 8'h61 && ascii <= 8'h7A) ? ascii - 8'h20 : ascii;

  always_comb begin
    entry = '0;
    case (folded)
      8'h20: begin
        entry.valid    = 1'b1;
        entry.is_space = 1'b1;
      end
      8'h41: entry = sym(3'd2, 5'b00001); // A .-
      8'h42: entry = sym(3'd4, 5'b01000); // B -...
      8'h43: entry = sym(3'd4, 5'b01010);
      8'h44: entry = sym(3'd3, 5'b00100);
      8'h45: entry = sym(3'd1, 5'b00000);
      8'h46: entry = sym(3'd4, 5'b00010);
      8'h47: entry = sym(3'd3, 5'b00110);
      8'h48: entry = sym(3'd4, 5'b00000);
      8'h49: entry = sym(3'd2, 5'b00000);
      8'h4A: entry = sym(3'd4, 5'b00111);
      8'h4B: entry = sym(3'd3, 5'b00101);
      8'h4C: entry = sym(3'd4, 5'b00100);
      8'h4D: entry = sym(3'd2, 5'b00011);
      8'h4E: entry = sym(3'd2, 5'b00010);
      8'h4F: entry = sym(3'd3, 5'b00111);
      8'h50: entry = sym(3'd4, 5'b00110);
      8'h51: entry = sym(3'd4, 5'b01101);
      8'h52: entry = sym(3'd3, 5'b00010);
      8'h53: entry = sym(3'd3, 5'b00000);
      8'h54: entry = sym(3'd1, 5'b00001);
      8'h55: entry = sym(3'd3, 5'b00001);
      8'h56: entry = sym(3'd4, 5'b00001);
      8'h57: entry = sym(3'd3, 5'b00011);
      8'h58: entry = sym(3'd4, 5'b01001);
      8'h59: entry = sym(3'd4, 5'b01011);
      8'h5A: entry = sym(3'd4, 5'b01100);
      8'h30: entry = sym(3'd5, 5'b11111); // 0 -----
      8'h31: entry = sym(3'd5, 5'b01111);
      8'h32: entry = sym(3'd5, 5'b00111);
      8'h33: entry = sym(3'd5, 5'b00011);
      8'h34: entry = sym(3'd5, 5'b00001);
      8'h35: entry = sym(3'd5, 5'b00000);
      8'h36: entry = sym(3'd5, 5'b10000);
      8'h37: entry = sym(3'd5, 5'b11000);
      8'h38: entry = sym(3'd5, 5'b11100);
      8'h39: entry = sym(3'd5, 5'b11110);
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// ASCII to Morse on/off keying at DOT_CYCLES clocks per unit; key rises the cycle after a transfer.
// char_ready is low for the whole character (marks, gaps, trailing gap); abort/rst return to IDLE next cycle.
module morse_keyer
  import morse_keyer_pkg::*;
#(
  parameter int DOT_CYCLES = 2160000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       abort,
  output logic       key,
  output logic       busy
);

  localparam int CW = $clog2(DOT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(DOT_CYCLES - 1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cyc_cnt, cyc_cnt_n;
  logic [1:0]    unit_cnt, unit_cnt_n;
  logic [2:0]    elem_cnt, elem_cnt_n;
  logic [4:0]    shreg, shreg_n;
  logic [4:0]    aligned;
  logic          key_n;
  logic          take;
  logic          unit_wrap;
  logic          phase_end;
  rom_entry_t    rom;

  morse_keyer_rom u_rom (
    .ascii (char_data),
    .entry (rom)
  );

  assign char_ready = (state == ST_IDLE) & ~rst;
  assign busy       = (state != ST_IDLE);
  assign take       = char_valid & char_ready;
  assign unit_wrap  = (cyc_cnt == CYC_LAST);
  assign phase_end  = unit_wrap && (unit_cnt == 2'd0);
  // first element moved to bit 4 so the shift register always presents the next element at its MSB
  assign aligned    = rom.pattern << (3'd5 - rom.len);

  always_comb begin
    state_n    = state;
    unit_cnt_n = unit_cnt;
    elem_cnt_n = elem_cnt;
    shreg_n    = shreg;
    cyc_cnt_n  = (state == ST_IDLE || unit_wrap) ? '0 : cyc_cnt + 1'b1;

    if (state != ST_IDLE && unit_wrap && unit_cnt != 2'd0)
      unit_cnt_n = unit_cnt - 2'd1;

    case (state)
      ST_IDLE: begin
        if (take && rom.valid) begin
          if (rom.is_space) begin
            state_n    = ST_GAP;
            unit_cnt_n = units_m1(WORD_EXTRA);
            elem_cnt_n = 3'd0;
          end else begin
            state_n    = ST_MARK;
            unit_cnt_n = aligned[4] ? units_m1(DASH_UNITS) : units_m1(DOT_UNITS);
            elem_cnt_n = rom.len;
            shreg_n    = aligned << 1;
          end
        end
      end
      ST_MARK: begin
        if (phase_end) begin
          state_n    = ST_GAP;
          elem_cnt_n = elem_cnt - 3'd1;
          unit_cnt_n = (elem_cnt != 3'd1) ? units_m1(ELEM_GAP) : units_m1(CHAR_GAP);
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          if (elem_cnt != 3'd0) begin
            state_n    = ST_MARK;
            unit_cnt_n = shreg[4] ? units_m1(DASH_UNITS) : units_m1(DOT_UNITS);
            shreg_n    = shreg << 1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // abort beats a same-cycle transfer: the character is discarded
    if (abort) begin
      state_n    = ST_IDLE;
      cyc_cnt_n  = '0;
      unit_cnt_n = 2'd0;
      elem_cnt_n = 3'd0;
      shreg_n    = 5'd0;
    end

    key_n = (state_n == ST_MARK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cyc_cnt  <= '0;
      unit_cnt <= 2'd0;
      elem_cnt <= 3'd0;
      shreg    <= 5'd0;
      key      <= 1'b0;
    end else begin
      state    <= state_n;
      cyc_cnt  <= cyc_cnt_n;
      unit_cnt <= unit_cnt_n;
      elem_cnt <= elem_cnt_n;
      shreg    <= shreg_n;
      key      <= key_n;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer at DOT_CYCLES=4: a Morse-string model queues the expected
// {key, char_ready, busy} for every cycle from the transfer onward; each scenario task compares them.
module tb_morse_keyer;

  localparam int DC = 4;
  localparam logic [2:0] IDLE_OBS = 3'b010;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       abort;
  logic       key;
  logic       busy;

  int tests_run = 0;
  int fails     = 0;
  int cyc_idx;
  int abort_at;
  int rst_at;

  logic [2:0] exp_q[$];
  logic [7:0] tx_q[$];

  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits[10]  = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  morse_keyer #(.DOT_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .abort      (abort),
    .key        (key),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic push_run(input logic k, input int units);
    repeat (units * DC) exp_q.push_back({k, 1'b0, 1'b1});
  endtask

  // Expected cycles for one character: its transfer cycle (idle) then the keyed body.
  task automatic push_char(input logic [7:0] c);
    string s;
    bit    sp;
    s  = "";
    sp = 1'b0;
    if (c >= 8'h41 && c <= 8'h5A)      s = letters[int'(c) - 65];
    else if (c >= 8'h61 && c <= 8'h7A) s = letters[int'(c) - 97];
    else if (c >= 8'h30 && c <= 8'h39) s = digits[int'(c) - 48];
    else if (c == 8'h20)               sp = 1'b1;
    exp_q.push_back(IDLE_OBS);
    if (sp) push_run(1'b0, 4);
    for (int i = 0; i < s.len(); i++) begin
      push_run(1'b1, (s[i] == 8'h2D) ? 3 : 1);
      push_run(1'b0, (i == s.len() - 1) ? 3 : 1);
    end
  endtask

  // One clock: drive inputs after the falling edge, observe 1 ns later.
  task automatic step(output logic [2:0] obs);
    @(negedge clk);
    abort = (cyc_idx == abort_at);
    rst   = (cyc_idx == rst_at);
    if (tx_q.size() > 0) begin
      char_valid = 1'b1;
      char_data  = tx_q[0];
    end else begin
      char_valid = 1'b0;
      char_data  = 8'h00;
    end
    #1;
    obs = {key, char_ready, busy};
    if (char_valid && char_ready) void'(tx_q.pop_front());
    cyc_idx++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; char_valid = 1'b0; abort = 1'b0; char_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({key, char_ready, busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_held: key,ready,busy=%b expected 000", {key, char_ready, busy});
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({key, char_ready, busy} !== IDLE_OBS) begin
      fails++;
      $display("FAIL reset_release: key,ready,busy=%b expected %b", {key, char_ready, busy}, IDLE_OBS);
    end
  endtask

  task automatic test_sequence(input string name, input string chars);
    logic [2:0] obs, e;
    int n;
    cyc_idx = 0; abort_at = -1; rst_at = -1;
    for (int i = 0; i < chars.len(); i++) begin
      push_char(chars[i]);
      tx_q.push_back(chars[i]);
    end
    exp_q.push_back(IDLE_OBS);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      step(obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s cycle T+%0d: key,ready,busy=%b expected %b", name, i, obs, e);
      end
    end
    tests_run++;
    if (tx_q.size() != 0) begin
      fails++;
      $display("FAIL %s consumed: %0d chars left, expected 0", name, tx_q.size());
      tx_q.delete();
    end
  endtask

  // 'T' interrupted at T+5 by abort or by rst; rst also forces char_ready low in its own cycle.
  task automatic test_abort(input bit use_rst);
    logic [2:0] obs, e;
    int n;
    cyc_idx = 0;
    abort_at = use_rst ? -1 : 5;
    rst_at   = use_rst ? 5 : -1;
    tx_q.push_back(8'h54);
    exp_q.push_back(IDLE_OBS);
    repeat (5) exp_q.push_back(3'b101);
    repeat (3) exp_q.push_back(IDLE_OBS);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      step(obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s cycle T+%0d: key,ready,busy=%b expected %b",
                 use_rst ? "rst_mid_char" : "abort_mid_char", i, obs, e);
      end
    end
    abort = 1'b0; rst = 1'b0; abort_at = -1; rst_at = -1;
  endtask

  task automatic test_abort_on_transfer;
    logic [2:0] obs, e;
    cyc_idx = 0; abort_at = 0; rst_at = -1;
    tx_q.push_back(8'h45);
    repeat (4) exp_q.push_back(IDLE_OBS);
    for (int i = 0; i < 4; i++) begin
      step(obs);
      e = exp_q.pop_front();
      tests_run++;
      if (obs !== e) begin
        fails++;
        $display("FAIL abort_on_transfer cycle T+%0d: key,ready,busy=%b expected %b", i, obs, e);
      end
    end
    abort = 1'b0; abort_at = -1;
  endtask

  initial begin
    rst = 1'b1; char_valid = 1'b0; abort = 1'b0; char_data = 8'h00;
    cyc_idx = 0; abort_at = -1; rst_at = -1;
    test_reset;
    test_sequence("E", "E");
    test_sequence("A", "A");
    test_sequence("lower_a", "a");
    test_sequence("digit_0", "0");
    test_sequence("back_to_back_E_E", "E E");
    test_sequence("dropped_hash", "#");
    test_sequence("mixed_K9z", "K9z");
    test_abort(1'b0);
    test_abort(1'b1);
    test_abort_on_transfer;
    @(negedge clk);
    char_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
